adder_operand_sequencer: RTL

- Sequencing stage directly upstream and downstream of the 16-bit carry-lookahead adder.
- Loads operands A and B from the board switches and holds them stable on the adder inputs.
- Waits a fixed settle time, then captures Sum/Cout into a result register for the hex display path.
- Supports an accumulate mode that feeds the last result back as the next A operand.

---
 rtl/adder_operand_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/adder_operand_sequencer.sv
// Operand and result sequencer wrapped around an external 16-bit adder.
// Holds A/B/Cin steady on the adder inputs. After a Run rising edge it waits
// SETTLE_CYCLES clocks, then captures {Cout, Sum} and the signed overflow flag.
// In accumulate mode the previous result is fed back as the next A operand.
module adder_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Sw,
  input  logic        LoadA,
  input  logic        LoadB,
  input  logic        Run,
  input  logic        Accumulate,
  input  logic        Cin,
  input  logic [15:0] Sum_in,
  input  logic        Cout_in,
  output logic [15:0] A_out,
  output logic [15:0] B_out,
  output logic        Cin_out,
  output logic [16:0] Result,
  output logic        Overflow,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] COUNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] count;
  logic       run_q;
  logic       run_rise;
  logic       any_load;
  logic       overflow_next;

  // Only a fresh edge on Run starts an add; a held level never retriggers.
  assign run_rise = Run & ~run_q;
  assign any_load = LoadA | LoadB;

  // Signed overflow: operands share a sign and the sum's sign differs from it.
  assign overflow_next = (A_out[15] == B_out[15]) & (Sum_in[15] != A_out[15]);

  // Sequencer FSM. Operand registers, counter and status flags are all
  // registered here so Busy/Done follow the state without a decode glitch.
  // NOTE: every register in this block is assigned with <= so that all of
  // them update together from the values present before the clock edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      run_q    <= 1'b0;
      A_out    <= '0;
      B_out    <= '0;
      Cin_out  <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      run_q <= Run;

      unique case (state)
        IDLE: begin
          if (LoadA) A_out <= Sw;
          if (LoadB) B_out <= Sw;
          // A load in the same cycle as the edge wins and the edge is lost.
          if (!any_load && run_rise) begin
            Cin_out <= Cin;
            count   <= COUNT_INIT;
            state   <= SETTLE;
            Busy    <= 1'b1;
          end
        end

        SETTLE: begin
          // Operands are frozen here; loads and Run edges are ignored.
          if (count == 4'd0) begin
            Result   <= {Cout_in, Sum_in};
            Overflow <= overflow_next;
            state    <= DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
          end else begin
            count <= count - 4'd1;
          end
        end

        DONE: begin
          if (any_load) begin
            if (LoadA) A_out <= Sw;
            if (LoadB) B_out <= Sw;
            state <= IDLE;
            Done  <= 1'b0;
          end else if (run_rise) begin
            // Carry-out of the previous result is dropped on feedback.
            if (Accumulate) A_out <= Result[15:0];
            Cin_out <= Cin;
            count   <= COUNT_INIT;
            state   <= SETTLE;
            Busy    <= 1'b1;
            Done    <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
